axi4lite2amm_rv_sc: RTL and testbench
=====================================

// Module: axi4lite2amm_rv_sc
// PURPOSE
//  AXI4-Lite slave to Avalon-MM master bridge with readdatavalid; one transaction in flight.
//  Sits directly upstream of the Avalon-MM to AHB-Lite bridge and drives its amm_* slave port.
//  Serialises the AXI read and write channels onto one Avalon-MM port.
//  Round-robin arbitration between reads and writes; optional timeout returns SLVERR.
// PARAMETERS
//  TIMEOUT   0   wait cycles per Avalon command phase / read-data phase before SLVERR; 0 = never
// PORTS
//  aclk              in   1   clock; all logic on rising edge
//  sreset            in   1   synchronous active-high reset
//  s_awaddr/awvalid/awready   in/in/out   32/1/1   AXI write address channel
//  s_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1   AXI write data channel
//  s_bresp/bvalid/bready      out/out/in  2/1/1    AXI write response channel
//  s_araddr/arvalid/arready   in/in/out   32/1/1   AXI read address channel
//  s_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1   AXI read data channel
//  amm_address       out  32  {addr[31:2],2'b00}
//  amm_writedata     out  32  captured wdata
//  amm_byteenable    out  4   wstrb on writes, 4'hF on reads
//  amm_write/amm_read  out 1  command strobes; never both high
//  amm_waitrequest   in   1   command held while high
//  amm_readdata      in   32  valid with amm_readdatavalid
//  amm_readdatavalid in   1   read data strobe
// BEHAVIOUR
//  Reset: sreset is synchronous and active-high; it is sampled on the aclk rising edge.
//  Reset: all valid/strobe outputs 0; awready=wready=arready=0 in the reset cycle, 1 afterwards.
//  Reset: bresp=rresp=2'b00; data/address outputs 0; all buffers empty; FSM to IDLE.
//  Reset mid-operation: the transaction is abandoned; no response is issued for it.
//  Skid buffers: AW, W and AR are each one entry deep.
//   - xREADY = ~buffer_full.
//   - A buffer fills on its valid&ready handshake and empties when its command is issued.
//   - AW and W are captured independently in either order.
//   - Each ready stays low until its buffer empties.
//  Write pending = AW full & W full. Read pending = AR full.
//  Arbiter: active in IDLE only. When both pending, grant the type not granted last.
//  Last grant resets to read, so a write wins the first tie.
//  FSM states:
//   IDLE: wait for a pending transaction -> WCMD or RCMD.
//     The registered command and address/data/byteenable appear in the next cycle.
//   WCMD: amm_write=1, outputs stable; when ~waitrequest -> BRESP (bresp OKAY).
//     Empty AW and W buffers.
//   RCMD: amm_read=1, outputs stable; when ~waitrequest -> RWAIT. Empty AR buffer.
//     If readdatavalid arrives in that same cycle, go straight to RRESP.
//   RWAIT: on readdatavalid, capture readdata -> RRESP (rresp OKAY).
//   BRESP: bvalid=1 until bready -> IDLE.
//   RRESP: rvalid=1, rdata stable until rready -> IDLE.
//  Timeout (TIMEOUT>0):
//   - Counter clears on entry to WCMD, RCMD and RWAIT.
//   - It increments each cycle spent waiting there.
//   - On reaching TIMEOUT: drop amm_read/write and respond SLVERR (2'b10).
//   - Read timeout gives rdata=0.
//   - Counter width is clog2(TIMEOUT+1).
//  readdatavalid outside RCMD/RWAIT, e.g. late after a timeout, is ignored.
//  Latency, zero waitstates: AW+W handshake at cycle 0, amm_write at cycle 1, bvalid at cycle 2.
//  Read path: AR at cycle 0, amm_read at cycle 1, readdatavalid at cycle 2, rvalid at cycle 3.
//  The next command cannot issue before the response handshake completes.
//  AXI prot signals are not used. Responses are only OKAY or SLVERR.
// TESTING
//  1 AW=0x100 and W=0xDEADBEEF/strb 0xF in one cycle, waitrequest=0, bready=1:
//    amm_write pulses 1 cycle with address 0x100 and byteenable F; bvalid at cycle 2, bresp 0.
//  2 W precedes AW by 3 cycles, strb=0x4, addr 0x203:
//    wready low after the W handshake; amm_address=0x200, byteenable=0x4; one amm_write.
//  3 AR=0x40, waitrequest high 4 cycles, readdatavalid 2 cycles later with 0x12345678:
//    amm_read held 5 cycles with stable outputs; rdata=0x12345678, rresp 0.
//  4 AW/W and AR pending together, 3 back-to-back rounds:
//    grants alternate W,R,W,R,W,R; never both strobes; each response matches its request.
//  5 TIMEOUT=8, readdatavalid never asserted:
//    rvalid after 8 RWAIT cycles, rresp 2'b10, rdata 0; a late readdatavalid is ignored.
//  6 sreset asserted during RWAIT and during BRESP with rready/bready=0:
//    all outputs 0 the next cycle; no stale response; the next transaction completes normally.

Source files
------------

// File: rtl/axi4lite2amm_rv_sc_if.sv
// AXI4-Lite slave channels plus Avalon-MM master port of the bridge.
// slave: bridge view; master: the AXI master / Avalon slave side.
interface axi4lite2amm_rv_sc_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] amm_address;
    logic [31:0] amm_writedata;
    logic [3:0]  amm_byteenable;
    logic        amm_write;
    logic        amm_read;
    logic        amm_waitrequest;
    logic [31:0] amm_readdata;
    logic        amm_readdatavalid;

    modport slave (
        input  s_awaddr, s_awvalid, output s_awready,
        input  s_wdata, s_wstrb, s_wvalid, output s_wready,
        output s_bresp, s_bvalid, input s_bready,
        input  s_araddr, s_arvalid, output s_arready,
        output s_rdata, s_rresp, s_rvalid, input s_rready,
        output amm_address, amm_writedata, amm_byteenable,
        output amm_write, amm_read,
        input  amm_waitrequest, amm_readdata, amm_readdatavalid
    );

    modport master (
        output s_awaddr, s_awvalid, input s_awready,
        output s_wdata, s_wstrb, s_wvalid, input s_wready,
        input  s_bresp, s_bvalid, output s_bready,
        output s_araddr, s_arvalid, input s_arready,
        input  s_rdata, s_rresp, s_rvalid, output s_rready,
        input  amm_address, amm_writedata, amm_byteenable,
        input  amm_write, amm_read,
        output amm_waitrequest, amm_readdata, amm_readdatavalid
    );
endinterface

// File: rtl/axi4lite2amm_rv_sc.sv
// AXI4-Lite slave to Avalon-MM master bridge, one transaction in flight.
// Round-robin read/write arbitration, optional per-phase timeout.
module axi4lite2amm_rv_sc #(
    parameter int unsigned TIMEOUT = 0
) (
    input logic                 aclk,
    input logic                 sreset,
    axi4lite2amm_rv_sc_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WCMD, RCMD, RWAIT, BRESP, RRESP} state_t;

    state_t        state_q, state_d;
    logic          rdy_q;
    logic          aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [31:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [31:0]   w_data_q, w_data_d;
    logic [3:0]    w_strb_q, w_strb_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic [1:0]    resp_q, resp_d;
    logic          last_wr_q, last_wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        aw_hs, w_hs, ar_hs, wr_go, rd_go, tmo;
    logic [31:0] aw_cur, ar_cur, wd_cur;
    logic [3:0]  ws_cur;

    assign bus.s_awready = rdy_q & ~aw_full_q;
    assign bus.s_wready  = rdy_q & ~w_full_q;
    assign bus.s_arready = rdy_q & ~ar_full_q;

    assign aw_hs = bus.s_awvalid & bus.s_awready;
    assign w_hs  = bus.s_wvalid & bus.s_wready;
    assign ar_hs = bus.s_arvalid & bus.s_arready;

    // A handshake in this cycle can be granted at once, bypassing the buffer.
    assign aw_cur = aw_full_q ? aw_addr_q : bus.s_awaddr;
    assign ar_cur = ar_full_q ? ar_addr_q : bus.s_araddr;
    assign wd_cur = w_full_q ? w_data_q : bus.s_wdata;
    assign ws_cur = w_full_q ? w_strb_q : bus.s_wstrb;
    assign wr_go  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
    assign rd_go  = ar_full_q | ar_hs;
    assign tmo    = (TIMEOUT > 0) && (cnt_q == TLAST);

    assign bus.amm_address    = addr_q;
    assign bus.amm_writedata  = wdata_q;
    assign bus.amm_byteenable = be_q;
    assign bus.amm_write      = (state_q == WCMD);
    assign bus.amm_read       = (state_q == RCMD);
    assign bus.s_bvalid       = (state_q == BRESP);
    assign bus.s_rvalid       = (state_q == RRESP);
    assign bus.s_bresp        = resp_q;
    assign bus.s_rresp        = resp_q;
    assign bus.s_rdata        = rdata_q;

    // Next state: skid buffers, arbiter, command and response sequencing.
    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q | aw_hs;
        w_full_d  = w_full_q | w_hs;
        ar_full_d = ar_full_q | ar_hs;
        aw_addr_d = aw_hs ? bus.s_awaddr : aw_addr_q;
        ar_addr_d = ar_hs ? bus.s_araddr : ar_addr_q;
        w_data_d  = w_hs ? bus.s_wdata : w_data_q;
        w_strb_d  = w_hs ? bus.s_wstrb : w_strb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q + CW'(1);
        unique case (state_q)
            IDLE: begin
                if (wr_go && (!rd_go || !last_wr_q)) begin
                    state_d   = WCMD;
                    addr_d    = {aw_cur[31:2], 2'b00};
                    wdata_d   = wd_cur;
                    be_d      = ws_cur;
                    last_wr_d = 1'b1;
                    cnt_d     = '0;
                end else if (rd_go) begin
                    state_d   = RCMD;
                    addr_d    = {ar_cur[31:2], 2'b00};
                    be_d      = 4'hF;
                    last_wr_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            WCMD: begin
                if (!bus.amm_waitrequest || tmo) begin
                    state_d   = BRESP;
                    resp_d    = bus.amm_waitrequest ? SLVERR : OKAY;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            RCMD: begin
                if (!bus.amm_waitrequest) begin
                    ar_full_d = 1'b0;
                    if (bus.amm_readdatavalid) begin
                        state_d = RRESP;
                        rdata_d = bus.amm_readdata;
                        resp_d  = OKAY;
                    end else begin
                        state_d = RWAIT;
                        cnt_d   = '0;
                    end
                end else if (tmo) begin
                    ar_full_d = 1'b0;
                    state_d   = RRESP;
                    rdata_d   = '0;
                    resp_d    = SLVERR;
                end
            end
            RWAIT: begin
                if (bus.amm_readdatavalid) begin
                    state_d = RRESP;
                    rdata_d = bus.amm_readdata;
                    resp_d  = OKAY;
                end else if (tmo) begin
                    state_d = RRESP;
                    rdata_d = '0;
                    resp_d  = SLVERR;
                end
            end
            BRESP: if (bus.s_bready) state_d = IDLE;
            RRESP: if (bus.s_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge aclk) begin
        if (sreset) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= 1'b1;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            aw_addr_q <= aw_addr_d;
            ar_addr_q <= ar_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi4lite2amm_rv_sc.sv
// Directed bench for axi4lite2amm_rv_sc (TIMEOUT=8).
// Cycle-exact checks of latency, skid buffers, arbitration, timeout, reset.
module tb_axi4lite2amm_rv_sc;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    axi4lite2amm_rv_sc_if bus();

    axi4lite2amm_rv_sc #(.TIMEOUT(8)) dut (
        .aclk  (clk),
        .sreset(rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] resp);
        logic aw_h, w_h, bv, got;
        bus.s_awaddr = a;
        bus.s_wdata = d;
        bus.s_wstrb = s;
        bus.s_awvalid = 1'b1;
        bus.s_wvalid = 1'b1;
        bus.s_bready = 1'b1;
        got = 1'b0;
        resp = 2'b11;
        for (int i = 0; i < 50 && !got; i++) begin
            aw_h = bus.s_awvalid & bus.s_awready;
            w_h = bus.s_wvalid & bus.s_wready;
            bv = bus.s_bvalid;
            if (bv) resp = bus.s_bresp;
            tick();
            if (aw_h) bus.s_awvalid = 1'b0;
            if (w_h) bus.s_wvalid = 1'b0;
            if (bv) got = 1'b1;
        end
        bus.s_awvalid = 1'b0;
        bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b0;
        chk("wr_done", got, 1);
    endtask

    task automatic do_rd(input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic [1:0] resp);
        logic ar_h, rv, got, pend;
        bus.s_araddr = a;
        bus.s_arvalid = 1'b1;
        bus.s_rready = 1'b1;
        got = 1'b0;
        pend = 1'b0;
        rd = '1;
        resp = 2'b11;
        for (int i = 0; i < 50 && !got; i++) begin
            bus.amm_readdatavalid = pend;
            bus.amm_readdata = pend ? d : 32'h0;
            pend = bus.amm_read & ~bus.amm_waitrequest;
            ar_h = bus.s_arvalid & bus.s_arready;
            rv = bus.s_rvalid;
            if (rv) begin
                rd = bus.s_rdata;
                resp = bus.s_rresp;
            end
            tick();
            if (ar_h) bus.s_arvalid = 1'b0;
            if (rv) got = 1'b1;
        end
        bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;
        bus.amm_readdatavalid = 1'b0;
        bus.amm_readdata = '0;
        chk("rd_done", got, 1);
    endtask

    initial begin
        logic [1:0]  r2;
        logic [31:0] r32;
        int          wai, wdi, ri, gw, gr, bn, rn, ng, nv;
        logic [5:0]  gs;
        logic        pend, aw_h, w_h, ar_h;
        logic [31:0] nxt;

        bus.s_awaddr = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata = '0;
        bus.s_wstrb = '0;
        bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b0;
        bus.s_araddr = '0;
        bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;
        bus.amm_waitrequest = 1'b0;
        bus.amm_readdata = '0;
        bus.amm_readdatavalid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_awready", bus.s_awready, 0);
        chk("rst_arready", bus.s_arready, 0);
        chk("rst_bvalid", bus.s_bvalid, 0);
        chk("rst_rvalid", bus.s_rvalid, 0);
        chk("rst_write", bus.amm_write, 0);
        chk("rst_addr", bus.amm_address, 0);
        rst = 1'b0;
        tick();
        chk("post_awready", bus.s_awready, 1);
        chk("post_wready", bus.s_wready, 1);

        // 1: AW and W together, zero waitstates
        bus.s_awaddr = 32'h100;
        bus.s_wdata = 32'hDEADBEEF;
        bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1'b1;
        bus.s_wvalid = 1'b1;
        bus.s_bready = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        bus.s_wvalid = 1'b0;
        chk("t1_write", bus.amm_write, 1);
        chk("t1_addr", bus.amm_address, 32'h100);
        chk("t1_be", bus.amm_byteenable, 4'hF);
        chk("t1_wdata", bus.amm_writedata, 32'hDEADBEEF);
        chk("t1_bv_c1", bus.s_bvalid, 0);
        tick();
        chk("t1_write_c2", bus.amm_write, 0);
        chk("t1_bvalid", bus.s_bvalid, 1);
        chk("t1_bresp", bus.s_bresp, 0);
        tick();
        bus.s_bready = 1'b0;
        chk("t1_bv_done", bus.s_bvalid, 0);

        // 2: W leads AW by 3 cycles, unaligned address
        bus.s_wdata = 32'hCAFEF00D;
        bus.s_wstrb = 4'h4;
        bus.s_wvalid = 1'b1;
        tick();
        bus.s_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wready", bus.s_wready, 0);
            chk("t2_nowr", bus.amm_write, 0);
            if (i < 2) tick();
        end
        bus.s_awaddr = 32'h203;
        bus.s_awvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        chk("t2_write", bus.amm_write, 1);
        chk("t2_addr", bus.amm_address, 32'h200);
        chk("t2_be", bus.amm_byteenable, 4'h4);
        chk("t2_wdata", bus.amm_writedata, 32'hCAFEF00D);
        tick();
        chk("t2_one_wr", bus.amm_write, 0);
        chk("t2_bvalid", bus.s_bvalid, 1);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
        chk("t2_wready_back", bus.s_wready, 1);

        // 3: read with 4 waitstates, data 2 cycles after command
        bus.amm_waitrequest = 1'b1;
        bus.s_araddr = 32'h40;
        bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.amm_waitrequest = 1'b0;
            chk("t3_read", bus.amm_read, 1);
            chk("t3_addr", bus.amm_address, 32'h40);
            chk("t3_be", bus.amm_byteenable, 4'hF);
            tick();
        end
        chk("t3_read_off", bus.amm_read, 0);
        chk("t3_rv_early", bus.s_rvalid, 0);
        tick();
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h12345678;
        tick();
        bus.amm_readdatavalid = 1'b0;
        bus.amm_readdata = '0;
        chk("t3_rvalid", bus.s_rvalid, 1);
        chk("t3_rdata", bus.s_rdata, 32'h12345678);
        chk("t3_rresp", bus.s_rresp, 0);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
        chk("t3_rv_done", bus.s_rvalid, 0);

        // 4: both types pending, three rounds
        wai = 0; wdi = 0; ri = 0; gw = 0; gr = 0;
        bn = 0; rn = 0; ng = 0; gs = '0;
        pend = 1'b0;
        nxt = '0;
        bus.s_bready = 1'b1;
        bus.s_rready = 1'b1;
        for (int c = 0; c < 200 && (bn < 3 || rn < 3); c++) begin
            bus.s_awvalid = (wai < 3);
            bus.s_awaddr = 32'h1000 + 32'(4 * wai);
            bus.s_wvalid = (wdi < 3);
            bus.s_wdata = 32'h5000_0000 + 32'(wdi);
            bus.s_wstrb = 4'hF;
            bus.s_arvalid = (ri < 3);
            bus.s_araddr = 32'h2000 + 32'(4 * ri);
            bus.amm_readdatavalid = pend;
            bus.amm_readdata = pend ? nxt : 32'h0;
            pend = 1'b0;
            chk("t4_excl", bus.amm_write & bus.amm_read, 0);
            if (bus.amm_write) begin
                chk("t4_waddr", bus.amm_address, 32'h1000 + 32'(4 * gw));
                chk("t4_wdata", bus.amm_writedata, 32'h5000_0000 + 32'(gw));
                gs = {gs[4:0], 1'b1};
                gw++;
                ng++;
            end
            if (bus.amm_read) begin
                chk("t4_raddr", bus.amm_address, 32'h2000 + 32'(4 * gr));
                nxt = 32'hA000_0000 + 32'(gr);
                pend = 1'b1;
                gs = {gs[4:0], 1'b0};
                gr++;
                ng++;
            end
            if (bus.s_bvalid) begin
                chk("t4_bresp", bus.s_bresp, 0);
                bn++;
            end
            if (bus.s_rvalid) begin
                chk("t4_rdata", bus.s_rdata, 32'hA000_0000 + 32'(rn));
                chk("t4_rresp", bus.s_rresp, 0);
                rn++;
            end
            aw_h = bus.s_awvalid & bus.s_awready;
            w_h = bus.s_wvalid & bus.s_wready;
            ar_h = bus.s_arvalid & bus.s_arready;
            tick();
            if (aw_h) wai++;
            if (w_h) wdi++;
            if (ar_h) ri++;
        end
        bus.s_awvalid = 1'b0;
        bus.s_wvalid = 1'b0;
        bus.s_arvalid = 1'b0;
        bus.s_bready = 1'b0;
        bus.s_rready = 1'b0;
        bus.amm_readdatavalid = 1'b0;
        chk("t4_order", gs, 6'b101010);
        chk("t4_grants", ng, 6);
        chk("t4_bcount", bn, 3);
        chk("t4_rcount", rn, 3);

        // 5: read timeout after 8 RWAIT cycles
        bus.s_araddr = 32'h80;
        bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        chk("t5_read", bus.amm_read, 1);
        tick();
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.s_rvalid) nv++;
            tick();
        end
        chk("t5_early", nv, 0);
        chk("t5_rvalid", bus.s_rvalid, 1);
        chk("t5_rresp", bus.s_rresp, 2'b10);
        chk("t5_rdata", bus.s_rdata, 0);
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h55;
        tick();
        bus.amm_readdatavalid = 1'b0;
        chk("t5_late_data", bus.s_rdata, 0);
        chk("t5_late_resp", bus.s_rresp, 2'b10);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
        chk("t5_rv_done", bus.s_rvalid, 0);
        bus.amm_readdatavalid = 1'b1;
        bus.amm_readdata = 32'h77;
        tick();
        bus.amm_readdatavalid = 1'b0;
        bus.amm_readdata = '0;
        chk("t5_idle_rdv", bus.s_rvalid, 0);
        chk("t5_arready", bus.s_arready, 1);

        // 6: reset during RWAIT, then during BRESP
        bus.s_araddr = 32'h44;
        bus.s_arvalid = 1'b1;
        tick();
        bus.s_arvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rv_rst", bus.s_rvalid, 0);
        chk("t6_ar_rst", bus.s_arready, 0);
        chk("t6_rd_rst", bus.amm_read, 0);
        chk("t6_addr_rst", bus.amm_address, 0);
        rst = 1'b0;
        tick();
        chk("t6_ar_back", bus.s_arready, 1);
        tick();
        chk("t6_no_stale_r", bus.s_rvalid, 0);
        bus.s_awaddr = 32'h300;
        bus.s_wdata = 32'h11112222;
        bus.s_wstrb = 4'h3;
        bus.s_awvalid = 1'b1;
        bus.s_wvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
        bus.s_wvalid = 1'b0;
        tick();
        chk("t6_bvalid", bus.s_bvalid, 1);
        rst = 1'b1;
        tick();
        chk("t6_bv_rst", bus.s_bvalid, 0);
        chk("t6_aw_rst", bus.s_awready, 0);
        chk("t6_wd_rst", bus.amm_writedata, 0);
        chk("t6_be_rst", bus.amm_byteenable, 0);
        chk("t6_bresp_rst", bus.s_bresp, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_no_stale_b", bus.s_bvalid, 0);
        do_wr(32'h304, 32'h33334444, 4'hF, r2);
        chk("t6_wr_resp", r2, 0);
        do_rd(32'h48, 32'h0BADF00D, r32, r2);
        chk("t6_rd_data", r32, 32'h0BADF00D);
        chk("t6_rd_resp", r2, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
